data_write_buffer: RTL

//  Posted-store buffer between the CPU data port and the unified memory's data port.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/write_buffer_fifo.sv | 74 +++++++
 rtl/data_write_buffer.sv | 104 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared types for the posted-store write buffer: the buffered entry layout and the
// drain-control states.
package wb_pkg;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wb_entry_t;

  typedef enum logic {
    WB_RUN   = 1'b0,
    WB_FLUSH = 1'b1
  } wb_state_e;

  // Stores are tracked per 32-bit word; byte offset is carried by the mask.
  function automatic logic [29:0] word_addr(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/write_buffer_fifo.sv
// Circular store queue for the write buffer, with a parallel word-address compare
// across all valid entries so loads can detect pending stores to the same word.
module write_buffer_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  wb_entry_t        i_push_entry,
  input  logic             i_pop,
  input  logic [29:0]      i_match_waddr,
  output wb_entry_t        o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count,
  output logic [DEPTH-1:0] o_hit
);

  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_valid;
  wb_entry_t        r_mem [DEPTH];

  logic w_push_ok;
  logic w_pop_ok;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_head    = r_mem[r_head];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_push_ok) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_pop_ok) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset; the valid bits gate every use of it.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_tail] <= i_push_entry;
  end

  always_comb begin
    o_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_hit[i] = r_valid[i] && (r_mem[i].waddr == i_match_waddr);
    end
  end

endmodule

// File: rtl/data_write_buffer.sv
// Posted-store buffer between the CPU data port and the memory data port: stores are
// queued and retired in order, loads pass through once no pending store targets their word.
//
// state    | meaning
// WB_RUN   | normal operation: accept stores, serve load misses, drain when port is free
// WB_FLUSH | draining everything; all CPU requests see busy until the queue empties
module data_write_buffer
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   cpu_addr,
  input  logic [DW-1:0]   cpu_din,
  input  logic [DW/8-1:0] cpu_mask,
  input  logic            cpu_write,
  input  logic            cpu_read,
  output logic [DW-1:0]   cpu_dout,
  output logic            cpu_busy,
  input  logic            flush,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_din,
  output logic [DW/8-1:0] mem_mask,
  output logic            mem_write,
  input  logic [DW-1:0]   mem_dout,
  input  logic            mem_busy,
  output logic            empty
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_state_e        r_state;
  wb_entry_t        w_push_entry;
  wb_entry_t        w_head;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [DEPTH-1:0] w_hit;
  logic             w_flush_active;
  logic             w_load_miss;
  logic             w_store_ok;
  logic             w_pop;
  logic             w_last_pop;

  assign w_push_entry = '{waddr: word_addr(cpu_addr), data: cpu_din, mask: cpu_mask};

  write_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk         (clk),
    .i_rst         (reset),
    .i_push        (w_store_ok),
    .i_push_entry  (w_push_entry),
    .i_pop         (w_pop),
    .i_match_waddr (word_addr(cpu_addr)),
    .o_head        (w_head),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_count       (w_count),
    .o_hit         (w_hit)
  );

  // A flush request takes effect in the cycle it is raised, before the state register catches up.
  assign w_flush_active = (r_state == WB_FLUSH) || (flush && !w_empty);
  assign w_load_miss    = cpu_read && !(|w_hit) && !w_flush_active;
  assign w_store_ok     = cpu_write && !w_full && !w_flush_active;
  assign w_last_pop     = w_pop && (w_count == CW'(1));
  assign empty          = w_empty;
  assign cpu_dout       = mem_dout;

  always_comb begin
    mem_addr  = {w_head.waddr, 2'b00};
    mem_din   = w_head.data;
    mem_mask  = w_head.mask;
    mem_write = 1'b0;
    w_pop     = 1'b0;
    if (w_load_miss) begin
      mem_addr = cpu_addr;
    end else if (!w_empty) begin
      mem_write = 1'b1;
      w_pop     = !mem_busy;
    end
  end

  always_comb begin
    cpu_busy = 1'b0;
    if (cpu_write)     cpu_busy = !w_store_ok;
    else if (cpu_read) cpu_busy = !w_load_miss || mem_busy;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WB_RUN;
    end else begin
      case (r_state)
        WB_RUN:   if (flush && !w_empty && !w_last_pop) r_state <= WB_FLUSH;
        WB_FLUSH: if (w_last_pop) r_state <= WB_RUN;
        default:  r_state <= WB_RUN;
      endcase
    end
  end

endmodule
